// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Holds the FSM state type and the hex-to-segment lookup.
package seg_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Active-high segments, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        seg = 7'h00;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to seven-segment pattern decoder.
module seg7_hex_decode
    import seg_sched_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg_display_sched.sv
// Time-multiplexes one seven-segment display between NUM_SRC requesters using
// round-robin slots with a strict-priority urgent override.
module seg_display_sched
    import seg_sched_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int HOLD_CYC  = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [NUM_SRC-1:0]     req,
    input  logic [NUM_SRC-1:0]     urgent,
    input  logic [4*NUM_SRC-1:0]   data,
    output logic [NUM_SRC-1:0]     grant,
    output logic [7:0]             uo_out,
    output logic                   busy
);

    localparam int IDX_W   = $clog2(NUM_SRC);
    localparam int MAX_CNT = (HOLD_CYC > BLANK_CYC) ? HOLD_CYC : BLANK_CYC;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_SRC-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // First set bit strictly after 'last', wrapping around the source range.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SRC-1:0] vec,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = int'(last) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!found && vec[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    state_t             state, next_state;
    logic [CNT_W-1:0]   hold_cnt, blank_cnt;
    logic [IDX_W-1:0]   cur_idx, rr_last;
    logic               cur_urgent;

    logic [NUM_SRC-1:0] urg_req;
    logic               any_req, any_urg;
    logic [IDX_W-1:0]   sel;
    logic               sel_urgent;
    logic [3:0]         sel_data;
    logic [6:0]         dec_seg;
    logic               slot_end;
    logic               take;

    logic [NUM_SRC-1:0] grant_d;
    logic [7:0]         seg_d;
    logic               busy_d;

    assign urg_req    = req & urgent;
    assign any_req    = |req;
    assign any_urg    = |urg_req;
    assign sel_urgent = any_urg;
    assign sel        = any_urg ? lowest_set(urg_req) : rr_pick(req, rr_last);
    assign sel_data   = data[4*sel +: 4];

    // An urgent slot is exempt from preemption, even by a lower-index urgent source.
    assign slot_end = (hold_cnt == HOLD_LAST) || !req[cur_idx] || (!cur_urgent && any_urg);

    seg7_hex_decode u_decode (
        .hex (sel_data),
        .seg (dec_seg)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        take       = 1'b0;
        if (!ena) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        if (BLANK_CYC == 0) begin
                            next_state = SHOW;
                            take       = 1'b1;
                        end else begin
                            next_state = BLANK;
                        end
                    end
                end
                BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        if (any_req) begin
                            next_state = SHOW;
                            take       = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
                SHOW: begin
                    if (slot_end) begin
                        if (!any_req) begin
                            next_state = IDLE;
                        end else if (BLANK_CYC == 0) begin
                            next_state = SHOW;
                            take       = 1'b1;
                        end else begin
                            next_state = BLANK;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; a slot keeps its latched digit until it ends.
    always_comb begin
        grant_d = '0;
        seg_d   = SEG_BLANK;
        busy_d  = (next_state != IDLE);
        if (take) begin
            grant_d = NUM_SRC'(1) << sel;
            seg_d   = {sel_urgent, dec_seg};
        end else if (next_state == SHOW) begin
            grant_d = grant;
            seg_d   = uo_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            blank_cnt  <= '0;
            cur_idx    <= '0;
            cur_urgent <= 1'b0;
            rr_last    <= IDX_W'(NUM_SRC - 1);
            grant      <= '0;
            uo_out     <= SEG_BLANK;
            busy       <= 1'b0;
        end else begin
            grant  <= grant_d;
            uo_out <= seg_d;
            busy   <= busy_d;

            if (take)                                         hold_cnt <= '0;
            else if (next_state == SHOW && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
            else if (next_state != SHOW)                      hold_cnt <= '0;

            if (state == BLANK && next_state == BLANK && blank_cnt != BLANK_LAST)
                blank_cnt <= blank_cnt + 1'b1;
            else if (next_state != BLANK || state != BLANK)
                blank_cnt <= '0;

            if (take) begin
                cur_idx    <= sel;
                cur_urgent <= sel_urgent;
                if (!sel_urgent) rr_last <= sel;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_sched.sv
// Self-checking bench for seg_display_sched: a slot-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_seg_display_sched;

    localparam int NUM_SRC   = 4;
    localparam int HOLD_CYC  = 16;
    localparam int BLANK_CYC = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ena;
    logic [NUM_SRC-1:0]   req;
    logic [NUM_SRC-1:0]   urgent;
    logic [4*NUM_SRC-1:0] data;
    logic [NUM_SRC-1:0]   grant;
    logic [7:0]           uo_out;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_display_sched #(
        .NUM_SRC   (NUM_SRC),
        .HOLD_CYC  (HOLD_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .req    (req),
        .urgent (urgent),
        .data   (data),
        .grant  (grant),
        .uo_out (uo_out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who is on the display (-1 = nobody), how long the
    // current slot has run, and how far into a blank gap we are (-1 = idle).
    int         m_cur;
    int         m_held;
    int         m_blank;
    int         m_rr;
    bit         m_urg;
    logic [7:0] m_seg;

    always @(posedge clk or negedge rst_n) begin : model_step
        int         cur_n, held_n, blank_n, rr_n;
        bit         urg_n, fin;
        logic [7:0] seg_n;
        logic [3:0] digit;
        if (!rst_n) begin
            m_cur   <= -1;
            m_held  <= 0;
            m_blank <= -1;
            m_rr    <= NUM_SRC - 1;
            m_urg   <= 1'b0;
            m_seg   <= 8'h00;
        end else begin
            cur_n = m_cur; held_n = m_held; blank_n = m_blank;
            rr_n = m_rr; urg_n = m_urg; seg_n = m_seg;
            if (!ena) begin
                cur_n = -1;
                blank_n = -1;
            end else if (m_cur >= 0) begin
                fin = (m_held == HOLD_CYC - 1) || !req[m_cur] || (!m_urg && (req & urgent) != 0);
                if (fin) begin
                    cur_n   = -1;
                    blank_n = (req != 0) ? 0 : -1;
                end else begin
                    held_n = m_held + 1;
                end
            end else if (m_blank >= 0) begin
                if (m_blank < BLANK_CYC - 1) begin
                    blank_n = m_blank + 1;
                end else if (req == 0) begin
                    blank_n = -1;
                end else begin
                    blank_n = -1;
                    held_n  = 0;
                    if ((req & urgent) != 0) begin
                        urg_n = 1'b1;
                        cur_n = -1;
                        for (int i = NUM_SRC - 1; i >= 0; i--)
                            if (req[i] && urgent[i]) cur_n = i;
                    end else begin
                        urg_n = 1'b0;
                        cur_n = -1;
                        for (int k = 1; k <= NUM_SRC; k++)
                            if (cur_n < 0 && req[(m_rr + k) % NUM_SRC]) cur_n = (m_rr + k) % NUM_SRC;
                        rr_n = cur_n;
                    end
                    digit = data[4*cur_n +: 4];
                    seg_n = {urg_n, seg_tab[digit]};
                end
            end else if (req != 0) begin
                blank_n = 0;
            end
            m_cur <= cur_n; m_held <= held_n; m_blank <= blank_n;
            m_rr <= rr_n; m_urg <= urg_n; m_seg <= seg_n;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_grant", grant,  (m_cur >= 0) ? (32'd1 << m_cur) : 32'd0);
            check("model_seg",   uo_out, (m_cur >= 0) ? m_seg : 8'h00);
            check("model_busy",  busy,   (m_cur >= 0 || m_blank >= 0) ? 1 : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Leaves the bench 8 ns after an edge with reset released and all inputs idle.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        ena    = 1'b1;
        req    = '0;
        urgent = '0;
        data   = '0;
        #6;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        req    = '0;
        urgent = '0;
        data   = '0;
        #23;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        #1;
        check("rst_grant", grant, 0);
        check("rst_seg",   uo_out, 8'h00);
        check("rst_busy",  busy, 0);

        // Reset mid-slot, then the first pick restarts at source 0.
        req = 4'b1111;
        tick(3);
        check("t1_first_grant", grant, 4'b0001);
        tick(4);
        rst_n = 1'b0;
        #1;
        check("t1_async_grant", grant, 0);
        check("t1_async_seg",   uo_out, 8'h00);
        check("t1_async_busy",  busy, 0);
        #5;
        rst_n = 1'b1;
        tick(3);
        check("t1_repick", grant, 4'b0001);

        // Single persistent requester blinks with an 18-cycle period.
        do_reset();
        data[11:8] = 4'hA;
        req = 4'b0100;
        tick(2);
        check("t2_latency_busy", busy, 1);
        check("t2_latency_gnt",  grant, 0);
        tick(1);
        check("t2_grant", grant, 4'b0100);
        check("t2_seg",   uo_out, 8'h77);
        data[11:8] = 4'h3;
        tick(15);
        check("t2_hold_last", uo_out, 8'h77);
        tick(1);
        check("t2_gap_seg", uo_out, 8'h00);
        tick(2);
        check("t2_again_seg", uo_out, 8'h4F);

        // Round-robin over 1011.
        do_reset();
        data = 16'h3210;
        req  = 4'b1011;
        tick(3);
        check("t3_rr0", grant, 4'b0001);
        tick(18);
        check("t3_rr1", grant, 4'b0010);
        tick(18);
        check("t3_rr2", grant, 4'b1000);
        check("t3_rr2_seg", uo_out, 8'h4F);
        tick(18);
        check("t3_rr3", grant, 4'b0001);

        // Urgent preemption at hold count 5; urgent slot is not preempted.
        do_reset();
        req = 4'b0001;
        tick(3);
        check("t4_src0_seg", uo_out, 8'h3F);
        tick(5);
        req[3] = 1'b1; urgent[3] = 1'b1; data[15:12] = 4'h1;
        tick(1);
        check("t4_pre_grant", grant, 0);
        check("t4_pre_seg",   uo_out, 8'h00);
        tick(2);
        check("t4_urg_grant", grant, 4'b1000);
        check("t4_urg_seg",   uo_out, 8'h86);
        urgent[0] = 1'b1;
        tick(3);
        check("t4_no_preempt", grant, 4'b1000);
        tick(20);

        // Early release of the current source hands over to the next in rotation.
        do_reset();
        req = 4'b0010;
        tick(3);
        check("t5_grant", grant, 4'b0010);
        tick(3);
        req = 4'b0101;
        tick(1);
        check("t5_drop", grant, 0);
        tick(2);
        check("t5_next", grant, 4'b0100);
        req = 4'b0000;
        tick(4);
        check("t5_idle_busy", busy, 0);

        // Enable low forces idle; re-enable restarts with the normal latency.
        do_reset();
        req = 4'b0001;
        tick(5);
        ena = 1'b0;
        tick(1);
        check("t6_off_seg",  uo_out, 8'h00);
        check("t6_off_busy", busy, 0);
        ena = 1'b1;
        req = 4'b0010;
        tick(3);
        check("t6_on_grant", grant, 4'b0010);

        // Hold expiry and preemption on the same edge.
        do_reset();
        req = 4'b0001;
        tick(18);
        req[2] = 1'b1; urgent[2] = 1'b1;
        tick(1);
        check("t7_end_grant", grant, 0);
        tick(2);
        check("t7_urg_grant", grant, 4'b0100);
        tick(5);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
